req_ack_monitor: RTL and testbench

REQ_ACK_MONITOR -- requirements
Module: req_ack_monitor

---
 rtl/req_ack_monitor.sv | 167 ++++++++++++++++
 tb/tb_req_ack_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_monitor.sv
// Per-channel request/acknowledge protocol monitor.
// It measures request-to-ack latency, flags protocol errors and counts completed transactions.
module req_ack_monitor #(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_LATENCY = 15
) (
    input  logic                           clk,
    input  logic                           reset_l,
    input  logic [CHANNELS-1:0]            bus_req,
    input  logic [CHANNELS-1:0]            bus_ack,
    input  logic [CHANNELS*DATA_WIDTH-1:0] bus_data,
    input  logic                           err_clr,
    output logic [CHANNELS-1:0]            done,
    output logic [CHANNELS*8-1:0]          latency,
    output logic [CHANNELS-1:0]            err,
    output logic [CHANNELS*3-1:0]          err_code,
    output logic [15:0]                    txn_count
);

    // state     | meaning
    // ST_IDLE   | no transaction outstanding on the channel
    // ST_WAIT   | request captured, counting cycles until ack or timeout
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_LAT   = 8'(MAX_LATENCY);
    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_SPUR = 3'd1;
    localparam logic [2:0] CODE_OVL  = 3'd2;
    localparam logic [2:0] CODE_TMO  = 3'd3;
    localparam logic [2:0] CODE_CHG  = 3'd4;

    logic [CHANNELS-1:0] done_d;
    logic [15:0]         txn_d;
    logic [15:0]         txn_q;
    logic [4:0]          done_sum;
    logic [16:0]         txn_sum;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        state_t                state_d, state_q;
        logic [7:0]            cnt_d, cnt_q;
        logic [DATA_WIDTH-1:0] cap_d, cap_q;
        logic [7:0]            lat_d, lat_q;
        logic                  done_ch_d, done_ch_q;
        logic                  err_d, err_q;
        logic [2:0]            code_d, code_q;
        logic [2:0]            det_code;
        logic                  req;
        logic                  ack;
        logic [DATA_WIDTH-1:0] data;

        assign req  = bus_req[ch];
        assign ack  = bus_ack[ch];
        assign data = bus_data[ch*DATA_WIDTH +: DATA_WIDTH];

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            cap_d     = cap_q;
            lat_d     = lat_q;
            done_ch_d = 1'b0;
            det_code  = CODE_NONE;

            case (state_q)
                ST_IDLE: begin
                    if (ack) begin
                        det_code = CODE_SPUR;
                    end
                    if (req) begin
                        cap_d   = data;
                        cnt_d   = 8'd1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Codes are tested lowest first so simultaneous errors record the lowest.
                    if (req && !ack) begin
                        det_code = CODE_OVL;
                    end else if (!ack && cnt_q >= MAX_LAT) begin
                        det_code = CODE_TMO;
                    end else if (data != cap_q) begin
                        det_code = CODE_CHG;
                    end

                    if (ack) begin
                        done_ch_d = 1'b1;
                        lat_d     = cnt_q;
                        state_d   = ST_IDLE;
                        if (req) begin
                            cap_d   = data;
                            cnt_d   = 8'd1;
                            state_d = ST_WAIT;
                        end
                    end else if (cnt_q >= MAX_LAT) begin
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            err_d  = err_q;
            code_d = code_q;
            if (err_clr) begin
                err_d  = 1'b0;
                code_d = CODE_NONE;
            end else if (!err_q && det_code != CODE_NONE) begin
                err_d  = 1'b1;
                code_d = det_code;
            end
        end

        always_ff @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                cap_q     <= '0;
                lat_q     <= '0;
                done_ch_q <= 1'b0;
                err_q     <= 1'b0;
                code_q    <= CODE_NONE;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                cap_q     <= cap_d;
                lat_q     <= lat_d;
                done_ch_q <= done_ch_d;
                err_q     <= err_d;
                code_q    <= code_d;
            end
        end

        assign done_d[ch]               = done_ch_d;
        assign done[ch]                 = done_ch_q;
        assign latency[ch*8 +: 8]       = lat_q;
        assign err[ch]                  = err_q;
        assign err_code[ch*3 +: 3]      = code_q;
    end

    // Count from the next-cycle done vector so txn_count moves together with the done pulses.
    always_comb begin
        done_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            done_sum = done_sum + 5'(done_d[i]);
        end
        txn_sum = {1'b0, txn_q} + 17'(done_sum);
        txn_d   = txn_sum[16] ? 16'hFFFF : txn_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            txn_q <= '0;
        end else begin
            txn_q <= txn_d;
        end
    end

    assign txn_count = txn_q;

endmodule

// File: tb/tb_req_ack_monitor.sv
// Directed bench for req_ack_monitor: expected done latencies go into per-channel queues
// and a monitor process pops them as done pulses appear; status outputs are checked inline.
module tb_req_ack_monitor;

    logic         clk = 1'b0;
    logic         reset_l;
    logic [3:0]   bus_req;
    logic [3:0]   bus_ack;
    logic [127:0] bus_data;
    logic         err_clr;
    logic [3:0]   done;
    logic [31:0]  latency;
    logic [3:0]   err;
    logic [11:0]  err_code;
    logic [15:0]  txn_count;

    int total = 0;
    int bad   = 0;
    int exp_txn;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    logic [7:0] exp_q3[$];

    req_ack_monitor #(.CHANNELS(4), .DATA_WIDTH(32), .MAX_LATENCY(15)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .bus_req   (bus_req),
        .bus_ack   (bus_ack),
        .bus_data  (bus_data),
        .err_clr   (err_clr),
        .done      (done),
        .latency   (latency),
        .err       (err),
        .err_code  (err_code),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] lat);
        case (c)
            0: exp_q0.push_back(lat);
            1: exp_q1.push_back(lat);
            2: exp_q2.push_back(lat);
            default: exp_q3.push_back(lat);
        endcase
    endtask

    task automatic set_data(input int c, input logic [31:0] v);
        bus_data[c*32 +: 32] = v;
    endtask

    // Drive one cycle of stimulus; returns at the falling edge after the sampling edge.
    task automatic tick(input logic [3:0] r, input logic [3:0] a, input logic c);
        bus_req = r;
        bus_ack = a;
        err_clr = c;
        @(negedge clk);
        bus_req = '0;
        bus_ack = '0;
        err_clr = 1'b0;
    endtask

    task automatic mon_ch(input int c);
        logic [7:0] e;
        int         sz;
        case (c)
            0: sz = exp_q0.size();
            1: sz = exp_q1.size();
            2: sz = exp_q2.size();
            default: sz = exp_q3.size();
        endcase
        if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected ch%0d: got done=1 expected no pulse", c);
        end else begin
            case (c)
                0: e = exp_q0.pop_front();
                1: e = exp_q1.pop_front();
                2: e = exp_q2.pop_front();
                default: e = exp_q3.pop_front();
            endcase
            check($sformatf("done_latency ch%0d", c), 32'(latency[c*8 +: 8]), 32'(e));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_l) begin
                for (int c = 0; c < 4; c++) begin
                    if (done[c]) mon_ch(c);
                end
            end
        end
    end

    initial begin
        reset_l  = 1'b0;
        bus_req  = '0;
        bus_ack  = '0;
        bus_data = '0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 0);
        check("rst_latency", latency, 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_txn", 32'(txn_count), 0);
        reset_l = 1'b1;

        // Basic transaction on ch0, latency 2
        set_data(0, 32'hfeed);
        tick(4'h1, 4'h0, 1'b0);
        tick(4'h0, 4'h0, 1'b0);
        push(0, 8'd2);
        tick(4'h0, 4'h1, 1'b0);
        exp_txn = 1;
        check("t1_txn", 32'(txn_count), 32'(exp_txn));
        check("t1_err", 32'(err), 0);
        check("t1_latency0", 32'(latency[7:0]), 2);
        tick(4'h0, 4'h0, 1'b0);
        check("t1_done_single", 32'(done), 0);

        // Spurious ack on ch1 then clear
        tick(4'h0, 4'h2, 1'b0);
        check("t2_err1", 32'(err[1]), 1);
        check("t2_code1", 32'(err_code[5:3]), 1);
        tick(4'h0, 4'h0, 1'b1);
        check("t2_err_clr", 32'(err), 0);
        check("t2_code_clr", 32'(err_code), 0);

        // Ack exactly at MAX_LATENCY is a valid completion
        tick(4'h2, 4'h0, 1'b0);
        repeat (14) tick(4'h0, 4'h0, 1'b0);
        push(1, 8'd15);
        tick(4'h0, 4'h2, 1'b0);
        exp_txn = 2;
        check("max_lat_value", 32'(latency[15:8]), 15);
        check("max_lat_err", 32'(err), 0);

        // Timeout on ch2
        tick(4'h4, 4'h0, 1'b0);
        repeat (14) tick(4'h0, 4'h0, 1'b0);
        check("t3_no_err_before_tmo", 32'(err), 0);
        tick(4'h0, 4'h0, 1'b0);
        check("t3_code_tmo", 32'(err_code[8:6]), 3);
        tick(4'h0, 4'h4, 1'b0);
        check("t3_code_retained", 32'(err_code[8:6]), 3);
        check("t3_txn", 32'(txn_count), 32'(exp_txn));
        tick(4'h0, 4'h0, 1'b1);

        // Overlapped request on ch3
        tick(4'h8, 4'h0, 1'b0);
        tick(4'h8, 4'h0, 1'b0);
        tick(4'h0, 4'h0, 1'b0);
        push(3, 8'd3);
        tick(4'h0, 4'h8, 1'b0);
        exp_txn = 3;
        check("t4_code_ovl", 32'(err_code[11:9]), 2);
        check("t4_latency3", 32'(latency[31:24]), 3);
        tick(4'h0, 4'h0, 1'b1);

        // Back-to-back on ch1
        tick(4'h2, 4'h0, 1'b0);
        push(1, 8'd1);
        tick(4'h2, 4'h2, 1'b0);
        push(1, 8'd1);
        tick(4'h0, 4'h2, 1'b0);
        exp_txn = 5;
        check("b2b_err", 32'(err), 0);
        check("b2b_txn", 32'(txn_count), 32'(exp_txn));

        // Spurious ack together with a new request on ch2
        tick(4'h4, 4'h4, 1'b0);
        check("spur_req_code", 32'(err_code[8:6]), 1);
        push(2, 8'd1);
        tick(4'h0, 4'h4, 1'b0);
        exp_txn = 6;
        check("spur_req_latency", 32'(latency[23:16]), 1);
        tick(4'h0, 4'h0, 1'b1);

        // Overlap and data change in one cycle record the lower code
        set_data(3, 32'h0000_00aa);
        tick(4'h8, 4'h0, 1'b0);
        set_data(3, 32'h0000_00bb);
        tick(4'h8, 4'h0, 1'b0);
        check("lowest_code", 32'(err_code[11:9]), 2);
        set_data(3, 32'h0000_00aa);
        push(3, 8'd2);
        tick(4'h0, 4'h8, 1'b0);
        exp_txn = 7;

        // Data change alone on ch0
        set_data(0, 32'h0000_0c0c);
        tick(4'h1, 4'h0, 1'b0);
        set_data(0, 32'h0000_0d0d);
        tick(4'h0, 4'h0, 1'b0);
        check("chg_code", 32'(err_code[2:0]), 4);
        set_data(0, 32'h0000_0c0c);
        push(0, 8'd2);
        tick(4'h0, 4'h1, 1'b0);
        exp_txn = 8;
        check("chg_txn", 32'(txn_count), 32'(exp_txn));
        tick(4'h0, 4'h0, 1'b1);

        // Clear wins over a coincident new error
        tick(4'h0, 4'h2, 1'b1);
        check("clr_wins_err", 32'(err), 0);
        check("clr_wins_code", 32'(err_code), 0);

        // Reset in the middle of a transaction
        set_data(0, 32'h0000_1234);
        tick(4'h1, 4'h0, 1'b0);
        set_data(0, 32'h0000_5678);
        tick(4'h0, 4'h0, 1'b0);
        check("r38_err_before", 32'(err[0]), 1);
        reset_l = 1'b0;
        #1;
        check("r38_done", 32'(done), 0);
        check("r38_latency", latency, 0);
        check("r38_err", 32'(err), 0);
        check("r38_code", 32'(err_code), 0);
        check("r38_txn", 32'(txn_count), 0);
        exp_txn = 0;
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        set_data(0, 32'h0000_1234);
        tick(4'h0, 4'h1, 1'b0);
        check("r38_spur_code", 32'(err_code[2:0]), 1);
        check("r38_no_done", 32'(done), 0);
        tick(4'h0, 4'h0, 1'b1);

        // All channels complete together, then run txn_count into saturation
        tick(4'hF, 4'h0, 1'b0);
        for (int c = 0; c < 4; c++) push(c, 8'd1);
        tick(4'h0, 4'hF, 1'b0);
        exp_txn = 4;
        check("all4_txn", 32'(txn_count), 32'(exp_txn));
        check("all4_done", 32'(done), 32'hF);
        tick(4'hF, 4'h0, 1'b0);
        for (int i = 0; i < 16400; i++) begin
            for (int c = 0; c < 4; c++) push(c, 8'd1);
            tick(4'hF, 4'hF, 1'b0);
            exp_txn = (exp_txn + 4 > 65535) ? 65535 : exp_txn + 4;
            check("sat_txn", 32'(txn_count), 32'(exp_txn));
        end
        for (int c = 0; c < 4; c++) push(c, 8'd1);
        tick(4'h0, 4'hF, 1'b0);
        check("sat_hold", 32'(txn_count), 32'hFFFF);
        tick(4'h0, 4'h0, 1'b0);

        check("q0_empty", exp_q0.size(), 0);
        check("q1_empty", exp_q1.size(), 0);
        check("q2_empty", exp_q2.size(), 0);
        check("q3_empty", exp_q3.size(), 0);
        check("final_err", 32'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
